sipo_receiver: RTL and testbench
================================

Name: sipo_receiver

Overview:
- Serial-in / parallel-out receiver: the receiving end of the single-bit serial link driven by the multiplier datapath's parallel-load serializer.
- Collects WORD_LENGTH serial bits, MSB first, framed by a load strobe.
- Presents the assembled word on a parallel bus with a one-cycle valid pulse.
- Flags framing violations: load arriving mid-frame.

Parameters:
- WORD_LENGTH, 5, width of the reassembled word in bits (legal range 2..32).
- CNT_WIDTH, $clog2(WORD_LENGTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data bit, sampled on every rising edge of clk.
- load  input  1  frame start; high in the same cycle as the first (MSB) bit.
- data_out  output  WORD_LENGTH  last completed word; holds until the next frame completes.
- valid  output  1  one-cycle pulse when data_out is updated.
- busy  output  1  high while a frame is in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse when load is seen during SHIFT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - data_out=0, valid=0, busy=0, frame_err=0.
  - Release is synchronous to the next rising edge.
- States: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - load=1 at edge E0: shift register <= {zeros, data_in}, counter <= 1, state <= SHIFT, busy <= 1.
  - load=0: remain in IDLE; data_in is ignored.
- SHIFT:
  - Each edge: shift register <= {shift[WORD_LENGTH-2:0], data_in}, counter++.
  - At edge E(WORD_LENGTH-1), where the counter equals WORD_LENGTH-1 before the edge, the last bit (LSB) is sampled and:
    - data_out <= the completed word;
    - valid <= 1;
    - state <= IDLE, busy <= 0, counter <= 0.
- Latency: valid and data_out are visible after edge E0+WORD_LENGTH-1, i.e. WORD_LENGTH-1 cycles after the edge that sampled load.
- valid is high for exactly one cycle, then cleared at the next edge.
- Bit order: first received bit becomes data_out[WORD_LENGTH-1]; last becomes data_out[0].
- Back-to-back frames: load=1 in the cycle valid is high is a legal new frame start (state is IDLE). Zero gap cycles are supported.
- load=1 during SHIFT:
  - It is ignored as a frame start; the current frame continues unchanged.
  - frame_err pulses for one cycle, asserted at the edge after the offending sample.
  - If the offending cycle is the final-bit cycle, the frame still completes (valid=1 and frame_err=1 in the same cycle).
- Reset mid-frame: the partial word is discarded, no valid is produced, and data_out returns to 0.
- data_out changes only on completion or reset. It never shows partial words.
- The counter never exceeds WORD_LENGTH-1. No wrap-around state exists outside SHIFT.

Test Plan (WORD_LENGTH=5):
1. Reset check: hold reset=0 with random data_in/load -> data_out=5'h00, valid=0, busy=0, frame_err=0 throughout. Release, then idle 3 cycles with load=0 -> outputs unchanged.
2. Single frame: load=1 with bits 1,0,1,1,0 on consecutive edges E0..E4 -> busy=1 after E0..E3. After E4: data_out=5'h16, valid=1 for one cycle, busy=0. data_out remains 5'h16 afterwards.
3. Back-to-back frames: frame 5'h1F (1,1,1,1,1), then load=1 in the valid cycle with frame 5'h01 (0,0,0,0,1) -> valid pulses exactly 5 cycles apart; data_out=5'h1F, then 5'h01.
4. Mid-frame load: start frame 5'h0A; assert load again at the 3rd bit -> frame_err pulses once, data_out=5'h0A on completion, and no second frame starts.
5. Reset mid-frame: start frame 5'h15; drive reset=0 asynchronously after 2 bits -> busy, data_out and valid drop to 0 immediately. After release, a new frame 5'h09 completes correctly with data_out=5'h09.
6. Load on final bit: frame 5'h03 with load=1 in the LSB cycle -> valid=1 and frame_err=1 in the same cycle, data_out=5'h03, state returns to IDLE.

Source files
------------

// File: rtl/sipo_receiver.sv
// Serial-in / parallel-out receiver for the single-bit link fed by the parallel-load serializer.
// Reassembles WORD_LENGTH bits, MSB first, framed by a load strobe. Flags a load that arrives mid-frame.
module sipo_receiver #(
   parameter int WORD_LENGTH = 5,
   parameter int CNT_WIDTH   = $clog2(WORD_LENGTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_in,
   input  logic                   load,
   output logic [WORD_LENGTH-1:0] data_out,
   output logic                   valid,
   output logic                   busy,
   output logic                   frame_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WORD_LENGTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t                 state, state_nxt;
   logic [WORD_LENGTH-1:0] shift_reg, shift_nxt;
   logic [WORD_LENGTH-1:0] data_nxt;
   logic [CNT_WIDTH-1:0]   bit_cnt, cnt_nxt;
   logic                   valid_nxt, busy_nxt, err_nxt;

   logic [WORD_LENGTH-1:0] first_word;
   logic [WORD_LENGTH-1:0] shifted_word;

   // The MSB lands in bit 0 at frame start and is walked up to the top by later shifts.
   assign first_word   = {{(WORD_LENGTH-1){1'b0}}, data_in};
   assign shifted_word = {shift_reg[WORD_LENGTH-2:0], data_in};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         bit_cnt   <= cnt_nxt;
         data_out  <= data_nxt;
         valid     <= valid_nxt;
         busy      <= busy_nxt;
         frame_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
      busy_nxt  = busy;
      err_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (load) begin
               shift_nxt = first_word;
               cnt_nxt   = CNT_ONE;
               state_nxt = SHIFT;
               busy_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            // A load here is a framing violation; it never restarts the frame in progress.
            err_nxt   = load;
            shift_nxt = shifted_word;
            if (bit_cnt == LAST_CNT) begin
               data_nxt  = shifted_word;
               valid_nxt = 1'b1;
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = bit_cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sipo_receiver.sv
// Randomised and directed bench for sipo_receiver (WORD_LENGTH=5).
// Expected outputs come from a bit-list frame model, not from the RTL structure.
module tb_sipo_receiver;

   localparam int WL = 5;

   logic          clk;
   logic          reset;
   logic          data_in;
   logic          load;
   logic [WL-1:0] data_out;
   logic          valid;
   logic          busy;
   logic          frame_err;

   int total;
   int bad;

   // Reference model: a frame is a list of received bits; the word is their binary value.
   bit      m_in_frame;
   int      m_bits[$];
   logic [WL-1:0] m_data;
   logic    m_valid;
   logic    m_busy;
   logic    m_err;

   sipo_receiver #(.WORD_LENGTH(WL)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .load      (load),
      .data_out  (data_out),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge(input logic ld, input logic din);
      int w;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!m_in_frame) begin
         if (ld) begin
            m_bits.delete();
            m_bits.push_back(int'(din));
            m_in_frame = 1'b1;
         end
      end else begin
         if (ld) m_err = 1'b1;
         m_bits.push_back(int'(din));
         if (m_bits.size() == WL) begin
            w = 0;
            foreach (m_bits[i]) w = w * 2 + m_bits[i];
            m_data     = WL'(w);
            m_valid    = 1'b1;
            m_in_frame = 1'b0;
         end
      end
      m_busy = m_in_frame;
   endtask

   // Apply one cycle of inputs, let the edge happen, and settle 1 ns past it.
   task automatic drive(input logic ld, input logic din);
      load    = ld;
      data_in = din;
      @(posedge clk);
      if (reset) model_edge(ld, din);
      else       model_reset();
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      load    = 1'b0;
      data_in = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         load    = 1'(($urandom & 1));
         data_in = 1'(($urandom & 1));
         @(posedge clk);
         #1;
         total++;
         if ({data_out, valid, busy, frame_err} !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got data=%h v=%b b=%b e=%b want all zero",
                     i, data_out, valid, busy, frame_err);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'(($urandom & 1)));
         total++;
         if ({data_out, valid, busy, frame_err} !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got data=%h v=%b b=%b e=%b want all zero",
                     i, data_out, valid, busy, frame_err);
         end
      end
   endtask

   task automatic test_single_frame();
      logic [WL-1:0] bits;
      bits = 5'b10110;
      for (int i = WL - 1; i >= 0; i--) begin
         drive(i == WL - 1, bits[i]);
         if (i > 0) begin
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
               bad++;
               $display("FAIL single_busy bit=%0d got busy=%b valid=%b want busy=1 valid=0",
                        i, busy, valid);
            end
         end
      end
      total++;
      if (data_out !== 5'h16 || valid !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_done got data=%h v=%b b=%b want data=16 v=1 b=0",
                  data_out, valid, busy);
      end
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      total++;
      if (data_out !== 5'h16 || valid !== 1'b0) begin
         bad++;
         $display("FAIL single_hold got data=%h v=%b want data=16 v=0", data_out, valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [WL-1:0] fa, fb;
      int            t_first, t_second, cyc;
      fa = 5'h1F;
      fb = 5'h01;
      t_first  = -1;
      t_second = -1;
      cyc = 0;
      for (int i = WL - 1; i >= 0; i--) begin
         drive(i == WL - 1, fa[i]);
         cyc++;
         if (valid) t_first = cyc;
      end
      total++;
      if (data_out !== 5'h1F || valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first got data=%h v=%b want data=1f v=1", data_out, valid);
      end
      for (int i = WL - 1; i >= 0; i--) begin
         drive(i == WL - 1, fb[i]);
         cyc++;
         if (valid && t_second < 0) t_second = cyc;
         if (i == WL - 1) begin
            total++;
            if (busy !== 1'b1 || data_out !== 5'h1F) begin
               bad++;
               $display("FAIL b2b_restart got busy=%b data=%h want busy=1 data=1f", busy, data_out);
            end
         end
      end
      total++;
      if (data_out !== 5'h01 || valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second got data=%h v=%b want data=01 v=1", data_out, valid);
      end
      total++;
      if (t_second - t_first !== 5) begin
         bad++;
         $display("FAIL b2b_spacing got %0d cycles want 5", t_second - t_first);
      end
      drive(1'b0, 1'b0);
   endtask

   task automatic test_mid_frame_load();
      logic [WL-1:0] f;
      int            errs;
      f = 5'h0A;
      errs = 0;
      for (int i = WL - 1; i >= 0; i--) begin
         drive((i == WL - 1) || (i == WL - 3), f[i]);
         if (frame_err) errs++;
         if (i == WL - 3) begin
            total++;
            if (frame_err !== 1'b1 || busy !== 1'b1) begin
               bad++;
               $display("FAIL midload_err got err=%b busy=%b want err=1 busy=1", frame_err, busy);
            end
         end
      end
      total++;
      if (data_out !== 5'h0A || valid !== 1'b1) begin
         bad++;
         $display("FAIL midload_done got data=%h v=%b want data=0a v=1", data_out, valid);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1);
         if (frame_err) errs++;
      end
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || data_out !== 5'h0A) begin
         bad++;
         $display("FAIL midload_nostart got busy=%b v=%b data=%h want busy=0 v=0 data=0a",
                  busy, valid, data_out);
      end
      total++;
      if (errs !== 1) begin
         bad++;
         $display("FAIL midload_errcount got %0d want 1", errs);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [WL-1:0] f;
      int            vcount;
      f = 5'h15;
      drive(1'b1, f[4]);
      drive(1'b0, f[3]);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || data_out !== 5'h00) begin
         bad++;
         $display("FAIL rstmid_async got busy=%b v=%b data=%h want all zero", busy, valid, data_out);
      end
      load = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1);
         if (valid) vcount++;
      end
      total++;
      if (vcount !== 0 || data_out !== 5'h00) begin
         bad++;
         $display("FAIL rstmid_novalid got valids=%0d data=%h want 0 and 00", vcount, data_out);
      end
      f = 5'h09;
      for (int i = WL - 1; i >= 0; i--) drive(i == WL - 1, f[i]);
      total++;
      if (data_out !== 5'h09 || valid !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_newframe got data=%h v=%b want data=09 v=1", data_out, valid);
      end
      drive(1'b0, 1'b0);
   endtask

   task automatic test_load_on_last_bit();
      logic [WL-1:0] f;
      f = 5'h03;
      for (int i = WL - 1; i >= 0; i--) drive((i == WL - 1) || (i == 0), f[i]);
      total++;
      if (valid !== 1'b1 || frame_err !== 1'b1 || data_out !== 5'h03 || busy !== 1'b0) begin
         bad++;
         $display("FAIL lastload got v=%b e=%b data=%h b=%b want v=1 e=1 data=03 b=0",
                  valid, frame_err, data_out, busy);
      end
      drive(1'b0, 1'b1);
      total++;
      if (valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL lastload_idle got v=%b e=%b b=%b want all zero", valid, frame_err, busy);
      end
   endtask

   task automatic test_random();
      logic ld, din;
      for (int i = 0; i < 400; i++) begin
         ld  = ($urandom_range(0, 3) == 0);
         din = 1'(($urandom & 1));
         drive(ld, din);
         total++;
         if (data_out !== m_data || valid !== m_valid || busy !== m_busy || frame_err !== m_err) begin
            bad++;
            $display("FAIL random cyc=%0d got data=%h v=%b b=%b e=%b want data=%h v=%b b=%b e=%b",
                     i, data_out, valid, busy, frame_err, m_data, m_valid, m_busy, m_err);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_mid_frame_load();
      test_reset_mid_frame();
      test_load_on_last_bit();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
